// File: rtl/fibonacci_pkg.sv
// fibonacci_pkg: shared types and constants for the Fibonacci generator/checker pair
//   fib_chk_state_t : checker FSM states
//   FIB_WIDTH       : default term width
//   LAST_IDX        : index of the last term representable in FIB_WIDTH bits
package fibonacci_pkg;
    typedef enum logic [2:0] {IDLE, SEED, TRACK, DONE, ERR} fib_chk_state_t;
    localparam int FIB_WIDTH = 14;
    localparam int LAST_IDX = 21;
endpackage

// File: rtl/fibonacci_next.sv
// fibonacci_next: last-two-terms pair and their sum
//   clk, reset (async active-low), clr (sync zero), ld (prev<=0, curr<=d), sh (prev<=curr, curr<=d)
//   nxt = prev + curr, nxt_ovf = carry of nxt, end_ovf = carry of curr + d (range end look-ahead)
module fibonacci_next #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             ld,
    input  logic             sh,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   nxt,
    output logic             nxt_ovf,
    output logic             end_ovf
);
    logic [WIDTH-1:0] prev, curr;
    logic [WIDTH:0] ahead;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= '0;
            curr <= '0;
        end else if (clr) begin
            prev <= '0;
            curr <= '0;
        end else if (ld || sh) begin
            prev <= ld ? '0 : curr;
            curr <= d;
        end
    end
    always_comb begin
        nxt = {1'b0, prev} + {1'b0, curr};
        ahead = {1'b0, curr} + {1'b0, d};
        nxt_ovf = nxt[WIDTH];
        end_ovf = ahead[WIDTH];
    end
endmodule

// File: rtl/fibonacci_checker.sv
// fibonacci_checker: verifies a valid-qualified stream is exactly 0, 1, 1, 2, 3, 5, ...
//   clk, reset (async active-low), clear (sync restart, beats f_valid), f_in/f_valid (term stream)
//   seq_index, locked, done, error, err_expected, err_got (all registered)
module fibonacci_checker
    import fibonacci_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int IDX_W = $clog2(LAST_IDX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] f_in,
    input  logic             f_valid,
    input  logic             clear,
    output logic [IDX_W-1:0] seq_index,
    output logic             locked,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] err_expected,
    output logic [WIDTH-1:0] err_got
);
    fib_chk_state_t state;
    logic [WIDTH:0] nxt, exp_v;
    logic nxt_ovf, end_ovf, run, bad, acc, mis;
    always_comb begin
        exp_v = state == TRACK ? nxt : (WIDTH+1)'(state == SEED);
        run = f_valid && !clear && (state == IDLE || state == SEED || state == TRACK);
        bad = {1'b0, f_in} != exp_v || (state == TRACK && nxt_ovf);
        acc = run && !bad;
        mis = run && bad;
    end
    fibonacci_next #(.WIDTH(WIDTH)) u_next (
        .clk(clk),
        .reset(reset),
        .clr(clear),
        .ld(acc && state != TRACK),
        .sh(acc && state == TRACK),
        .d(f_in),
        .nxt(nxt),
        .nxt_ovf(nxt_ovf),
        .end_ovf(end_ovf)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || clear) begin
            state <= IDLE;
            seq_index <= '0;
            locked <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            err_expected <= '0;
            err_got <= '0;
        end else if (acc) begin
            // end_ovf: the term after this one would not fit, so this is the last one
            state <= state == IDLE ? SEED : state == SEED ? TRACK : end_ovf ? DONE : TRACK;
            seq_index <= state == IDLE ? '0 : state == SEED ? IDX_W'(1) : seq_index + 1'b1;
            locked <= locked || state == TRACK;
            done <= state == TRACK && end_ovf;
        end else if (mis) begin
            state <= ERR;
            locked <= 1'b0;
            error <= 1'b1;
            err_expected <= exp_v[WIDTH-1:0];
            err_got <= f_in;
        end
    end
endmodule

// File: tb/tb_fibonacci_checker.sv
// tb_fibonacci_checker: directed checks of fibonacci_checker against hand-computed values
module tb_fibonacci_checker;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [13:0] f_in = '0;
    logic f_valid = 1'b0;
    logic clear = 1'b0;
    logic [4:0] seq_index;
    logic locked, done, error;
    logic [13:0] err_expected, err_got;
    int n_tests = 0;
    int n_fail = 0;
    int fib [22] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987,
                     1597, 2584, 4181, 6765, 10946};

    fibonacci_checker dut (
        .clk(clk),
        .reset(reset),
        .f_in(f_in),
        .f_valid(f_valid),
        .clear(clear),
        .seq_index(seq_index),
        .locked(locked),
        .done(done),
        .error(error),
        .err_expected(err_expected),
        .err_got(err_got)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int v);
        f_in = 14'(v);
        f_valid = 1'b1;
        @(posedge clk);
        #1;
        f_valid = 1'b0;
    endtask

    task automatic restart();
        clear = 1'b1;
        f_valid = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_idx"}, 32'(seq_index), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_errexp"}, 32'(err_expected), 0);
        chk({tag, "_errgot"}, 32'(err_got), 0);
    endtask

    initial begin
        #2;
        all_zero("rst");
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            send(fib[i]);
            chk($sformatf("short_idx%0d", i), 32'(seq_index), i);
            chk($sformatf("short_lock%0d", i), 32'(locked), i >= 2 ? 1 : 0);
            chk($sformatf("short_err%0d", i), 32'(error), 0);
        end

        restart();
        all_zero("clr1");
        for (int i = 0; i < 22; i++) begin
            send(fib[i]);
            chk($sformatf("full_done%0d", i), 32'(done), i == 21 ? 1 : 0);
        end
        chk("full_idx", 32'(seq_index), 21);
        chk("full_lock", 32'(locked), 1);
        send(17711 & 16'h3FFF);
        chk("post_done_idx", 32'(seq_index), 21);
        chk("post_done_done", 32'(done), 1);
        chk("post_done_err", 32'(error), 0);

        restart();
        send(0); send(1); send(1); send(2); send(4);
        chk("bad4_err", 32'(error), 1);
        chk("bad4_exp", 32'(err_expected), 3);
        chk("bad4_got", 32'(err_got), 4);
        chk("bad4_idx", 32'(seq_index), 3);
        chk("bad4_lock", 32'(locked), 0);
        send(5); send(0);
        chk("bad4_hold_err", 32'(error), 1);
        chk("bad4_hold_exp", 32'(err_expected), 3);
        chk("bad4_hold_got", 32'(err_got), 4);
        chk("bad4_hold_idx", 32'(seq_index), 3);

        restart();
        send(1);
        chk("first1_err", 32'(error), 1);
        chk("first1_exp", 32'(err_expected), 0);
        chk("first1_got", 32'(err_got), 1);
        restart();
        all_zero("clr2");
        send(0); send(1); send(1);
        chk("after_clr_idx", 32'(seq_index), 2);
        chk("after_clr_lock", 32'(locked), 1);
        chk("after_clr_err", 32'(error), 0);

        restart();
        for (int i = 0; i < 4; i++) begin
            send(fib[i]);
            for (int g = 0; g < 3; g++) begin
                f_in = 14'($urandom);
                @(posedge clk);
                #1;
            end
        end
        chk("gap_idx", 32'(seq_index), 3);
        chk("gap_err", 32'(error), 0);
        chk("gap_lock", 32'(locked), 1);

        restart();
        for (int i = 0; i <= 10; i++) send(fib[i]);
        chk("mid_idx", 32'(seq_index), 10);
        #2 reset = 1'b0;
        #1;
        all_zero("async");
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        f_in = 14'd7;
        f_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        f_valid = 1'b0;
        clear = 1'b0;
        chk("clr_valid_err", 32'(error), 0);
        chk("clr_valid_got", 32'(err_got), 0);
        send(0);
        chk("post_rst_idx", 32'(seq_index), 0);
        chk("post_rst_err", 32'(error), 0);
        send(1);
        chk("post_rst_idx1", 32'(seq_index), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fibonacci_checker.md
# fibonacci_checker

Receive-side companion to the `fibonacci` sequence generator. It samples a 14-bit term stream qualified by a valid strobe and checks that the stream is exactly 0, 1, 1, 2, 3, 5, … (each term is the sum of the two before it). It tracks the index of each accepted term, flags the first mismatch with captured diagnostics, and reports completion at the last representable term. It sits on the generator output, in the DUT or in a bench harness.

## Interface
- `WIDTH`, default 14: term width in bits; must match the generator.
- `IDX_W`, default 5: width of the index and count outputs. Must satisfy 2^IDX_W > `LAST_IDX`.
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset.
- `f_in`, input, `WIDTH` bits: term under test.
- `f_valid`, input, 1 bit: `f_in` is sampled on a rising edge only when this is high.
- `clear`, input, 1 bit: synchronous restart to IDLE; takes priority over `f_valid`.
- `seq_index`, output, `IDX_W` bits: index of the last accepted term (F0 = 0).
- `locked`, output, 1 bit: high once F2 has been verified and the stream is still error-free.
- `done`, output, 1 bit: high once the last representable term has been accepted.
- `error`, output, 1 bit: sticky mismatch flag.
- `err_expected`, output, `WIDTH` bits: term value expected at the failing sample.
- `err_got`, output, `WIDTH` bits: term value received at the failing sample.

## Operation
- States:
  - IDLE: expects 0.
  - SEED: expects 1.
  - TRACK: expects prev + curr.
  - DONE.
  - ERR.
- Internal registers: `prev` and `curr` (the last two accepted terms) and the expected value `nxt = prev + curr`, computed at `WIDTH+1` bits.
- Accepting a term in IDLE or SEED:
  - Loads `prev`/`curr`.
  - Sets `seq_index` to 0 or 1 respectively.
  - Advances state: IDLE → SEED, SEED → TRACK.
- Accepting a term in TRACK:
  - Shifts the pair: `prev ← curr`, `curr ← f_in`.
  - Increments `seq_index`.
  - Sets `locked` on the first TRACK acceptance.
- Range end:
  - When the next `nxt` would exceed 2^WIDTH − 1, the term just accepted is the last representable one (`LAST_IDX`).
  - The block then goes to DONE and `done` rises.
  - For `WIDTH` = 14, `LAST_IDX` = 21 (F21 = 10946; F22 = 17711 does not fit).
- Mismatch in IDLE, SEED or TRACK (`f_in` ≠ expected):
  - State → ERR; `error` = 1; `locked` = 0.
  - `err_expected` and `err_got` are captured.
  - `seq_index` holds its value.
- In DONE or ERR, valid samples are ignored; all outputs hold.
- `clear`:
  - Returns the block to IDLE.
  - Zeroes `seq_index`, `locked`, `done`, `error`, `err_expected`, `err_got`, `prev` and `curr`.
  - A sample presented in the same cycle as `clear` is discarded.
- `reset` low: same register values as `clear`, but applied asynchronously and regardless of `clk`.
- `f_valid` low: nothing changes, whatever the state.

## Timing
- Every output is registered.
- The effect of a sample accepted at edge N is visible immediately after edge N (zero-cycle latency in sampled terms).
- Back-to-back valid samples (one per clock) are sustained indefinitely; there is no backpressure.
- `error`, `done` and `locked` each change only on the edge that performs the accept or mismatch.
- Asserting `reset` mid-stream clears everything asynchronously.
- After `reset` deasserts, the first valid sample is checked against 0.
- Gaps in `f_valid` do not affect checking; only the order of valid samples matters.

## Structure
- Package `fibonacci_pkg` contains:
  - The state enum `fib_chk_state_t` (IDLE, SEED, TRACK, DONE, ERR).
  - The default `WIDTH` = 14.
  - The constant `LAST_IDX` = 21, shared with the generator for end-of-range agreement.
- One sub-module, `fibonacci_next`: holds the `prev`/`curr` pair, with load, shift and clear controls.
  - Outputs the `WIDTH+1`-bit sum `nxt`.
  - Outputs the flag `nxt_ovf` (carry bit of `nxt`).
- The top level contains the FSM, the index counter and the error capture.

## Test plan
- Reset low, then release; stream 0, 1, 1, 2, 3, 5, 8 with `f_valid` = 1 every cycle:
  - `seq_index` counts 0 → 6.
  - `locked` rises on the third sample.
  - `error` stays 0.
- Full stream F0 through F21 (… 6765, 10946):
  - `done` rises on the edge accepting 10946, with `seq_index` = 21.
  - A further sample of 17711 & 0x3FFF is ignored.
- Stream 0, 1, 1, 2, 4:
  - On the fifth sample, `error` = 1, `err_expected` = 3, `err_got` = 4, `seq_index` = 3, `locked` = 0.
  - Later valid samples change nothing.
- First sample is 1:
  - Immediate error, with `err_expected` = 0, `err_got` = 1.
  - `clear` then returns to IDLE; a following stream 0, 1, 1 passes.
- Stream 0, 1, 1, 2 with `f_valid` dropped for 3 cycles between terms (`f_in` = garbage while low):
  - No error; `seq_index` = 3.
- Mid-stream at `seq_index` = 10:
  - Pulse `reset` low between clock edges; all outputs go to 0 immediately.
  - `clear` asserted together with a valid wrong sample: no error is recorded.
